// File: rtl/pipe_fetch_queue.sv
// ---------------------------------------------------------------------------
// pipe_fetch_queue
//
// Small in-order instruction queue between the fetch stage (PC register plus
// instruction memory) and the decode stage. Each accepted fetch stores the
// pair {FetchPC+4, FetchInstr}. The oldest pair is presented to ID.
//
// Parameters:
//   DEPTH          number of entries (2..16, need not be a power of two)
//
// Ports:
//   Clk            clock, all state changes on the rising edge
//   Reset          synchronous active-high reset, overrides every other input
//   FetchValid     FetchPC/FetchInstr carry a valid fetch this cycle
//   FetchPC        address of the fetched instruction
//   FetchInstr     instruction word from instruction memory
//   IDStall        decode cannot consume the head entry this cycle
//   Flush          drop every queued entry and any enqueue this cycle
//   PCHold         queue full; the PC register must hold its value
//   IDValid        head entry valid
//   IDInstr        head instruction, 0 (NOP) when IDValid=0
//   IDPCPlus4      head entry's PC+4, 0 when IDValid=0
//
// Optional (macro FETCHQ_STATS_EN):
//   HoldCycles     saturating count of non-reset cycles with PCHold=1
//   FlushedEntries saturating sum of the occupancy discarded by each Flush
// ---------------------------------------------------------------------------
module pipe_fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        FetchValid,
    input  logic [31:0] FetchPC,
    input  logic [31:0] FetchInstr,
    input  logic        IDStall,
    input  logic        Flush,
    output logic        PCHold,
    output logic        IDValid,
    output logic [31:0] IDInstr,
    output logic [31:0] IDPCPlus4
`ifdef FETCHQ_STATS_EN
    ,
    output logic [31:0] HoldCycles,
    output logic [31:0] FlushedEntries
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Each entry is {pc_plus4, instr}.
    logic [63:0]   mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;

    logic        enq;
    logic        deq;
    logic [63:0] head;
    logic [63:0] wr_data;

    // Outputs depend only on registered state: no Fetch* -> ID* bypass.
    assign PCHold  = (count_reg == FULL_CNT);
    assign IDValid = (count_reg != '0);
    assign head    = mem_reg[rd_ptr_reg];
    assign IDInstr   = IDValid ? head[31:0]  : 32'h0000_0000;
    assign IDPCPlus4 = IDValid ? head[63:32] : 32'h0000_0000;

    // A full queue refuses the fetch even when the head drains this cycle,
    // so PCHold never depends on IDStall.
    assign enq = FetchValid && !PCHold && !Flush;
    assign deq = IDValid && !IDStall && !Flush;

    // 32-bit add; 32'hFFFFFFFC wraps to 0.
    assign wr_data = {FetchPC + 32'd4, FetchInstr};

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (Flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (enq) begin
                wr_ptr_next = (wr_ptr_reg == LAST_IDX) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (deq) begin
                rd_ptr_next = (rd_ptr_reg == LAST_IDX) ? '0 : rd_ptr_reg + 1'b1;
            end
            if (enq && !deq) begin
                count_next = count_reg + 1'b1;
            end else if (deq && !enq) begin
                count_next = count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // One write-enabled register per entry; storage is cleared on reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    mem_reg[gi] <= '0;
                end else if (enq && (wr_ptr_reg == PW'(gi))) begin
                    mem_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

`ifdef FETCHQ_STATS_EN
    logic [31:0] hold_cycles_reg;
    logic [31:0] flushed_entries_reg;
    logic [32:0] flush_sum;

    // One extra bit catches overflow of the accumulated flush count.
    assign flush_sum = {1'b0, flushed_entries_reg} + 33'(count_reg);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_cycles_reg     <= '0;
            flushed_entries_reg <= '0;
        end else begin
            if (PCHold && (hold_cycles_reg != 32'hFFFF_FFFF)) begin
                hold_cycles_reg <= hold_cycles_reg + 32'd1;
            end
            if (Flush) begin
                flushed_entries_reg <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
            end
        end
    end

    assign HoldCycles     = hold_cycles_reg;
    assign FlushedEntries = flushed_entries_reg;
`endif

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_pipe_fetch_queue
//
// Bench for pipe_fetch_queue (DEPTH=2). A table of directed vectors walks the
// streaming, full/hold, full-with-drain, flush, PC wrap and reset cases with
// hand-written expectations. Pointer wrap-around and random traffic are then
// checked against a queue-based reference model of the fetch queue.
// ---------------------------------------------------------------------------
module tb_pipe_fetch_queue;

    localparam int DEPTH = 2;

    logic        Clk;
    logic        Reset;
    logic        FetchValid;
    logic [31:0] FetchPC;
    logic [31:0] FetchInstr;
    logic        IDStall;
    logic        Flush;
    logic        PCHold;
    logic        IDValid;
    logic [31:0] IDInstr;
    logic [31:0] IDPCPlus4;
`ifdef FETCHQ_STATS_EN
    logic [31:0] HoldCycles;
    logic [31:0] FlushedEntries;
`endif

    pipe_fetch_queue #(.DEPTH(DEPTH)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .FetchValid (FetchValid),
        .FetchPC    (FetchPC),
        .FetchInstr (FetchInstr),
        .IDStall    (IDStall),
        .Flush      (Flush),
        .PCHold     (PCHold),
        .IDValid    (IDValid),
        .IDInstr    (IDInstr),
        .IDPCPlus4  (IDPCPlus4)
`ifdef FETCHQ_STATS_EN
        ,
        .HoldCycles     (HoldCycles),
        .FlushedEntries (FlushedEntries)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: queued {pc+4, instr} entries, oldest first.
    logic [63:0] mq[$];
    logic [31:0] m_hold;
    logic [31:0] m_flushed;

    typedef struct {
        logic        rst;
        logic        fv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        stall;
        logic        flush;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pcp4;
        logic        e_hold;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Applies one cycle of inputs, advances the model across the same edge,
    // and leaves outputs ready to sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic fv, input logic [31:0] pc,
                        input logic [31:0] ins, input logic st, input logic fl);
        bit full;
        bit m_enq;
        bit m_deq;
        Reset      = rst;
        FetchValid = fv;
        FetchPC    = pc;
        FetchInstr = ins;
        IDStall    = st;
        Flush      = fl;
        full  = (mq.size() == DEPTH);
        m_enq = fv && !full && !fl;
        m_deq = (mq.size() != 0) && !st && !fl;
        if (rst) begin
            mq.delete();
            m_hold    = 0;
            m_flushed = 0;
        end else begin
            if (full && m_hold != 32'hFFFF_FFFF) m_hold++;
            if (fl) m_flushed = m_flushed + 32'(mq.size());
            if (fl) begin
                mq.delete();
            end else begin
                if (m_deq) void'(mq.pop_front());
                if (m_enq) mq.push_back({pc + 32'd4, ins});
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        logic        v;
        logic [63:0] h;
        v = (mq.size() != 0);
        h = v ? mq[0] : 64'd0;
        chk({tag, " valid"}, {31'd0, IDValid}, {31'd0, v});
        chk({tag, " instr"}, IDInstr, h[31:0]);
        chk({tag, " pcp4"},  IDPCPlus4, h[63:32]);
        chk({tag, " hold"},  {31'd0, PCHold}, {31'd0, (mq.size() == DEPTH)});
`ifdef FETCHQ_STATS_EN
        chk({tag, " holdcyc"}, HoldCycles, m_hold);
        chk({tag, " flushed"}, FlushedEntries, m_flushed);
`endif
    endtask

    initial begin
        Reset = 1'b0; FetchValid = 1'b0; FetchPC = '0; FetchInstr = '0;
        IDStall = 1'b0; Flush = 1'b0;
        m_hold = 0; m_flushed = 0;

        //           rst  fv  pc            instr          st  fl   v  instr          pcp4          hold
        vecs[0]  = '{1'b1,1'b0,32'h0,        32'h0,         1'b0,1'b0, 1'b0,32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b0,1'b1,32'h0,        32'h20080005,  1'b0,1'b0, 1'b1,32'h20080005, 32'h4,        1'b0};
        vecs[2]  = '{1'b0,1'b1,32'h4,        32'h11111111,  1'b0,1'b0, 1'b1,32'h11111111, 32'h8,        1'b0};
        vecs[3]  = '{1'b0,1'b1,32'h8,        32'h22222222,  1'b0,1'b0, 1'b1,32'h22222222, 32'hC,        1'b0};
        vecs[4]  = '{1'b0,1'b0,32'h0,        32'h0,         1'b0,1'b0, 1'b0,32'h0,        32'h0,        1'b0};
        vecs[5]  = '{1'b0,1'b1,32'h10,       32'hA0A0A0A0,  1'b1,1'b0, 1'b1,32'hA0A0A0A0, 32'h14,       1'b0};
        vecs[6]  = '{1'b0,1'b1,32'h14,       32'hA1A1A1A1,  1'b1,1'b0, 1'b1,32'hA0A0A0A0, 32'h14,       1'b1};
        vecs[7]  = '{1'b0,1'b1,32'h18,       32'hA2A2A2A2,  1'b1,1'b0, 1'b1,32'hA0A0A0A0, 32'h14,       1'b1};
        vecs[8]  = '{1'b0,1'b1,32'h18,       32'hA2A2A2A2,  1'b0,1'b0, 1'b1,32'hA1A1A1A1, 32'h18,       1'b0};
        vecs[9]  = '{1'b0,1'b1,32'h18,       32'hA2A2A2A2,  1'b0,1'b0, 1'b1,32'hA2A2A2A2, 32'h1C,       1'b0};
        vecs[10] = '{1'b0,1'b0,32'h0,        32'h0,         1'b1,1'b0, 1'b1,32'hA2A2A2A2, 32'h1C,       1'b0};
        vecs[11] = '{1'b0,1'b1,32'h1C,       32'hA3A3A3A3,  1'b1,1'b0, 1'b1,32'hA2A2A2A2, 32'h1C,       1'b1};
        vecs[12] = '{1'b0,1'b1,32'h40,       32'hB0B0B0B0,  1'b0,1'b1, 1'b0,32'h0,        32'h0,        1'b0};
        vecs[13] = '{1'b0,1'b1,32'h80,       32'hB1B1B1B1,  1'b0,1'b0, 1'b1,32'hB1B1B1B1, 32'h84,       1'b0};
        vecs[14] = '{1'b0,1'b1,32'hFFFFFFFC, 32'hC0C0C0C0,  1'b0,1'b0, 1'b1,32'hC0C0C0C0, 32'h0,        1'b0};
        vecs[15] = '{1'b0,1'b0,32'h0,        32'h0,         1'b1,1'b0, 1'b1,32'hC0C0C0C0, 32'h0,        1'b0};
        vecs[16] = '{1'b0,1'b1,32'h100,      32'hD0D0D0D0,  1'b1,1'b0, 1'b1,32'hC0C0C0C0, 32'h0,        1'b1};
        vecs[17] = '{1'b1,1'b1,32'h104,      32'hD1D1D1D1,  1'b1,1'b1, 1'b0,32'h0,        32'h0,        1'b0};
        vecs[18] = '{1'b0,1'b0,32'h0,        32'h0,         1'b1,1'b0, 1'b0,32'h0,        32'h0,        1'b0};

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].rst, vecs[i].fv, vecs[i].pc, vecs[i].instr, vecs[i].stall, vecs[i].flush);
            chk($sformatf("vec%0d valid", i), {31'd0, IDValid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d instr", i), IDInstr, vecs[i].e_instr);
            chk($sformatf("vec%0d pcp4", i),  IDPCPlus4, vecs[i].e_pcp4);
            chk($sformatf("vec%0d hold", i),  {31'd0, PCHold}, {31'd0, vecs[i].e_hold});
            $display("vec%0d: valid=%0b instr=%h pcp4=%h hold=%0b", i, IDValid, IDInstr, IDPCPlus4, PCHold);
        end

`ifdef FETCHQ_STATS_EN
        // Fill with stall, then PCHold is seen on three edges (last one is the
        // flush edge) while two entries are discarded.
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h200, 32'hE0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h204, 32'hE1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h208, 32'hE2, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h208, 32'hE2, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h208, 32'hE2, 1'b1, 1'b1);
        chk("stats holdcyc", HoldCycles, 32'd3);
        chk("stats flushed", FlushedEntries, 32'd2);
        $display("stats: hold=%0d flushed=%0d", HoldCycles, FlushedEntries);
`endif

        // Pointer wrap: five rounds of fill-while-stalled then drain.
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk_model("wrap reset");
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < DEPTH; k++) begin
                step(1'b0, 1'b1, 32'h1000 + 32'(r * 64 + k * 4), 32'($urandom), 1'b1, 1'b0);
                chk_model($sformatf("wrap r%0d fill%0d", r, k));
            end
            for (int k = 0; k < DEPTH; k++) begin
                step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
                chk_model($sformatf("wrap r%0d drain%0d", r, k));
                $display("wrap r%0d drain%0d: valid=%0b pcp4=%h", r, k, IDValid, IDPCPlus4);
            end
        end

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic        rst;
            logic        fv;
            logic        st;
            logic        fl;
            logic [31:0] pc;
            rst = ($urandom_range(0, 63) == 0);
            fv  = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 2) == 0);
            fl  = ($urandom_range(0, 15) == 0);
            pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if ($urandom_range(0, 31) == 0) pc = 32'hFFFF_FFFC;
            step(rst, fv, pc, 32'($urandom), st, fl);
            chk_model($sformatf("rand%0d", n));
            $display("rand%0d: rst=%0b fv=%0b st=%0b fl=%0b -> valid=%0b pcp4=%h hold=%0b",
                     n, rst, fv, st, fl, IDValid, IDPCPlus4, PCHold);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
